// File: rtl/ecp8_pkg.sv
// Shared definitions for the instruction encoder: class codes, encoder
// state encoding, the buffered entry layout and the byte-packing helpers.
package ecp8_pkg;

    localparam logic [1:0] CLS_IMM    = 2'd0;
    localparam logic [1:0] CLS_ALU    = 2'd1;
    localparam logic [1:0] CLS_COPY   = 2'd2;
    localparam logic [1:0] CLS_BRANCH = 2'd3;

    // Widest program address an entry can carry; encoders use the low bits.
    localparam int ENC_ADDR_W_MAX = 16;

    typedef enum logic [1:0] {
        ENC_ACTIVE = 2'd0,
        ENC_FULL   = 2'd1,
        ENC_DONE   = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [ENC_ADDR_W_MAX-1:0] addr;
        logic [7:0]                data;
    } enc_entry_t;

    // ALU and BRANCH only carry a 3-bit selector; the upper field bits
    // must be zero for the operation to be legal.
    function automatic logic enc_reject(input logic [1:0] cls, input logic [5:0] field);
        return ((cls == CLS_ALU) || (cls == CLS_BRANCH)) && (field[5:3] != 3'd0);
    endfunction

    function automatic logic [7:0] enc_byte(input logic [1:0] cls, input logic [5:0] field);
        if ((cls == CLS_ALU) || (cls == CLS_BRANCH)) begin
            return {cls, 3'b000, field[2:0]};
        end
        return {cls, field};
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry synchronous FIFO holding encoded bytes with their addresses.
// ent0 is always the head; ent1 only holds data when two entries are queued.
module enc_fifo2
    import ecp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  enc_entry_t push_data,
    input  logic       pop,
    output enc_entry_t head,
    output logic [1:0] occ
);

    logic [1:0] occ_q, occ_d;
    enc_entry_t ent0_q, ent0_d;
    enc_entry_t ent1_q, ent1_d;
    logic       do_push, do_pop;

    // Next-entry and occupancy computation; a push into a full FIFO is only
    // honoured when a pop frees a slot in the same cycle.
    always_comb begin
        occ_d   = occ_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        do_pop  = pop && (occ_q != 2'd0);
        do_push = push && ((occ_q != 2'd2) || do_pop);
        case ({do_push, do_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
        if (flush) begin
            occ_d = 2'd0;
        end
    end

    // Occupancy is control and is reset; entry payloads are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign head = ent0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/ins_encoder.sv
// Encodes (class, field) operations into instruction bytes, tags them with
// sequential program addresses and streams them out through a 2-entry FIFO.
module ins_encoder
    import ecp8_pkg::*;
#(
    parameter int PROG_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [5:0]        in_field,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PROG_DEPTH);

    enc_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic       flush, accept, reject, push, pop;
    enc_entry_t push_entry, head;
    logic [1:0] occ;

    // Handshake decode; in_ready never looks at out_ready.
    always_comb begin
        flush      = rst || clear;
        in_ready   = !flush && (state_q == ENC_ACTIVE) && (occ != 2'd2);
        accept     = in_valid && in_ready;
        reject     = accept && enc_reject(in_class, in_field);
        push       = accept && !reject;
        pop        = (occ != 2'd0) && out_ready;
        push_entry = '{addr: ENC_ADDR_W_MAX'(count_q[ADDR_W-1:0]),
                       data: enc_byte(in_class, in_field)};
        count_d    = count_q + (push ? CNT_W'(1) : CNT_W'(0));
        err_d      = reject;
    end

    // Next-state logic: stop accepting once the program is full, then wait
    // for the buffer to drain before signalling completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ENC_ACTIVE: begin
                if (push && (count_q + CNT_W'(1) == DEPTH_C)) begin
                    state_d = ENC_FULL;
                end
            end
            ENC_FULL: begin
                if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
                    state_d = ENC_DONE;
                end
            end
            ENC_DONE: state_d = ENC_DONE;
            default:  state_d = ENC_ACTIVE;
        endcase
    end

    // Control registers; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= ENC_ACTIVE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    enc_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    if (ADDR_W < ENC_ADDR_W_MAX) begin : g_addr_pad
        logic unused_addr_bits;
        assign unused_addr_bits = ^head.addr[ENC_ADDR_W_MAX-1:ADDR_W];
    end

    // Head payload is gated so an empty buffer presents zeros.
    always_comb begin
        out_valid = (occ != 2'd0);
        out_addr  = out_valid ? head.addr[ADDR_W-1:0] : '0;
        out_data  = out_valid ? head.data : 8'd0;
        err       = err_q;
        count     = count_q;
        done      = (state_q == ENC_DONE);
    end

endmodule

// File: tb/tb_ins_encoder.sv
// Bench for ins_encoder: a reference model predicts handshakes and queues
// the expected bytes; a monitor pops and compares every byte consumed.
// A second small-depth instance exercises the full/done path directly.
module tb_ins_encoder;
    import ecp8_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] in_class = 2'd0;
    logic [5:0] in_field = 6'd0;

    logic       in_ready, out_valid, err, done;
    logic [7:0] out_addr, out_data;
    logic [8:0] count;

    logic       b_in_ready, b_out_valid, b_err, b_done;
    logic [1:0] b_out_addr;
    logic [7:0] b_out_data;
    logic [2:0] b_count;

    always #5 clk = ~clk;

    ins_encoder #(.PROG_DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_field(in_field),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .err(err), .count(count), .done(done)
    );

    ins_encoder #(.PROG_DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_class(in_class), .in_field(in_field),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_addr(b_out_addr), .out_data(b_out_data),
        .err(b_err), .count(b_count), .done(b_done)
    );

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    int   m_pend = 0;
    int   m_err = 0;
    int   last_addr = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int enc_model(input int c, input int f);
        if (c == 1 || c == 3) return c * 64 + (f % 8);
        return c * 64 + f;
    endfunction

    // One clock cycle of stimulus for the 256-deep instance, checked against the model.
    task automatic cyc(input logic v, input logic [1:0] c, input logic [5:0] f,
                       input logic ordy, input logic clr);
        int  exp_rdy, acc, rej, pop;
        exp_t e;
        in_valid = v; in_class = c; in_field = f; out_ready = ordy; clear = clr;
        #1;
        exp_rdy = (!clr && m_cnt < 256 && m_pend < 2) ? 1 : 0;
        chk("in_ready", int'(in_ready), exp_rdy);
        chk("out_valid", int'(out_valid), (m_pend > 0) ? 1 : 0);
        chk("count", int'(count), m_cnt);
        chk("err", int'(err), m_err);
        chk("done", int'(done), (m_cnt == 256 && m_pend == 0) ? 1 : 0);
        if (clr) begin
            m_cnt = 0; m_pend = 0; m_err = 0;
            sb.delete();
        end else begin
            pop = (m_pend > 0 && ordy) ? 1 : 0;
            acc = (v && exp_rdy != 0) ? 1 : 0;
            rej = (acc != 0 && (c == 2'd1 || c == 2'd3) && f[5:3] != 3'd0) ? 1 : 0;
            m_err = rej;
            if (acc != 0 && rej == 0) begin
                e.addr = m_cnt % 256;
                e.data = enc_model(int'(c), int'(f));
                sb.push_back(e);
                m_cnt++;
                m_pend++;
            end
            m_pend -= pop;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every byte the memory side consumes must match the queue head.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_byte", int'(out_data), -1);
            end else begin
                e = sb.pop_front();
                chk("out_addr", int'(out_addr), e.addr);
                chk("out_data", int'(out_data), e.data);
                last_addr = int'(out_addr);
            end
        end
    end

    initial begin
        logic [1:0] rc;
        logic [5:0] rf;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_done", int'(done), 0);

        // One operation of each class with the memory side always ready.
        cyc(1'b1, 2'd0, 6'h2A, 1'b1, 1'b0);
        cyc(1'b1, 2'd1, 6'd3, 1'b1, 1'b0);
        cyc(1'b1, 2'd2, {3'd2, 3'd5}, 1'b1, 1'b0);
        cyc(1'b1, 2'd3, 6'd4, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0);

        // Illegal ALU field: consumed, err pulses, no byte, address unchanged.
        cyc(1'b1, 2'd1, 6'h0B, 1'b1, 1'b0);
        chk("reject_err_pulse", int'(err), 1);
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0);
        chk("reject_err_clear", int'(err), 0);
        cyc(1'b1, 2'd0, 6'h11, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0);

        // Backpressure: two accepted, third waits until after the first pop.
        cyc(1'b1, 2'd0, 6'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 6'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 6'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 6'd3, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 6'd3, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0);

        // Clear with two bytes buffered and an operation on offer.
        cyc(1'b1, 2'd0, 6'd7, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 6'd8, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 6'd9, 1'b0, 1'b1);
        chk("clear_count", int'(count), 0);
        chk("clear_out_valid", int'(out_valid), 0);
        cyc(1'b1, 2'd2, 6'h3F, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0);

        // Depth-4 instance: five offered, four emitted, done after last pop.
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 2'd0, 6'(k), 1'b1, 1'b0);
            chk("b_in_ready", int'(b_in_ready), (k < 3) ? 1 : 0);
            if (k < 4) begin
                chk("b_out_valid", int'(b_out_valid), 1);
                chk("b_out_addr", int'(b_out_addr), k);
                chk("b_out_data", int'(b_out_data), k);
                chk("b_done_early", int'(b_done), 0);
            end else begin
                chk("b_out_valid_end", int'(b_out_valid), 0);
                chk("b_done", int'(b_done), 1);
                chk("b_count", int'(b_count), 4);
            end
        end
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b0);

        // Randomized run to the full 256-byte program.
        cyc(1'b0, 2'd0, 6'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4000 && m_cnt < 256; i++) begin
            rc = 2'($urandom_range(3));
            rf = 6'($urandom);
            if ((rc == 2'd1 || rc == 2'd3) && $urandom_range(3) != 0) rf[5:3] = 3'd0;
            cyc(($urandom_range(3) != 0), rc, rf, ($urandom_range(9) < 7), 1'b0);
        end
        chk("depth_reached", m_cnt, 256);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 2'd0, 6'd5, 1'b1, 1'b0);
        end
        chk("max_last_addr", last_addr, 255);
        chk("max_count", int'(count), 256);
        chk("max_done", int'(done), 1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ins_encoder.md
# ins_encoder

Encodes structured Overture operations (class plus operand field) into 8-bit instruction bytes and streams them, tagged with sequential program addresses, toward program memory. It performs the inverse of the instruction decoder's class split: bits [7:6] select IMM/ALU/COPY/BRANCH. It sits between the program loader and the program memory write port, and buffers up to two encoded bytes behind a valid/ready handshake.

## Interface
Parameters:
- PROG_DEPTH, 256: number of program bytes that may be emitted before the block is full (1..256).
- ADDR_W, 8: width of out_addr; must satisfy 2^ADDR_W >= PROG_DEPTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush: same effect as rst, for use mid-operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts operation this cycle.
- in_class  in  2  0=IMM, 1=ALU, 2=COPY, 3=BRANCH.
- in_field  in  6  operand: IMM value; COPY {src[5:3],dst[2:0]}; ALU op [2:0]; BRANCH cond [2:0].
- out_valid  out  1  encoded byte available.
- out_ready  in  1  memory side consumes byte.
- out_addr  out  ADDR_W  program address of byte.
- out_data  out  8  encoded instruction.
- err  out  1  one-cycle pulse: last accepted operation rejected.
- count  out  ADDR_W+1  bytes accepted for encoding since reset/clear.
- done  out  1  full and buffer drained.

## Operation
- Encoding: out_data = {in_class, payload}. IMM payload=in_field; COPY payload=in_field; ALU/BRANCH payload={3'b000, in_field[2:0]}.
- Reject rule: class ALU or BRANCH with in_field[5:3] != 0. The handshake still completes (consumed). Nothing is buffered, address and count are unchanged, and err pulses the next cycle.
- Accept: in_valid && in_ready. A valid operation is pushed into a 2-entry FIFO with tag addr = count[ADDR_W-1:0]. count then increments by 1.
- Pop: out_valid && out_ready removes the head entry. out_valid = FIFO not empty. out_addr/out_data show the head entry.
- State machine (registered):
  - ACTIVE: in_ready = (occupancy < 2). Goes to FULL when a push makes count == PROG_DEPTH.
  - FULL: in_ready=0. The FIFO keeps draining. Goes to DONE when occupancy becomes 0.
  - DONE: in_ready=0, done=1. Stays until rst/clear.
- PROG_DEPTH=256 with ADDR_W=8: the last byte uses addr 0xFF. count reaches 256 and never wraps; there is no address wrap-around.
- clear or rst has priority over every other event in the same cycle. Effect: FIFO emptied, count=0, state=ACTIVE, err=0. Any operation offered that cycle is not accepted, because in_ready is forced low while clear or rst is asserted.
- Simultaneous push and pop with occupancy 1 leaves occupancy at 1, with the new entry at the head next cycle.
- in_ready depends on registered state and clear/rst only, never on out_ready.

## Timing
- Reset values: in_ready=1 (after the reset cycle), out_valid=0, out_addr=0, out_data=0, err=0, count=0, done=0, state=ACTIVE.
- Latency: an operation accepted at edge N gives out_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 byte/cycle while out_ready is held high. Occupancy never exceeds 1 in that case.
- With out_ready low, two operations are accepted and then in_ready drops. It rises again the cycle after the first pop.
- err is asserted in the cycle after the rejected handshake, for exactly one cycle.
- done is asserted in the cycle after the final pop.

## Structure
- Shared package ecp8_pkg holds:
  - class constants CLS_IMM=2'd0, CLS_ALU=2'd1, CLS_COPY=2'd2, CLS_BRANCH=2'd3;
  - the state enum ENC_ACTIVE/ENC_FULL/ENC_DONE;
  - the FIFO entry struct {addr, data}.
- One sub-module: enc_fifo2, a 2-entry synchronous FIFO with push/pop/flush and occupancy output. The encode and reject logic stay in ins_encoder.

## Test plan
- Encode each class with out_ready=1:
  - IMM 0x2A -> data 0x2A, addr 0;
  - ALU op 3 -> 0x43, addr 1;
  - COPY src 2 dst 5 -> 0x95, addr 2;
  - BRANCH cond 4 -> 0xC4, addr 3;
  - one byte per cycle, latency 1.
- Reject: ALU with field 0x0B -> err pulse 1 cycle, no out_valid, next valid op gets the unchanged addr, count unchanged.
- Backpressure: out_ready=0 with 3 ops offered -> 2 accepted, in_ready=0. Raise out_ready -> bytes appear in order; the third op is accepted the cycle after the first pop.
- Full: PROG_DEPTH=4, 5 ops offered -> addrs 0..3 emitted, fifth not accepted, done=1 the cycle after the last pop.
- Full at max depth: PROG_DEPTH=256 -> last out_addr=0xFF, count=256, no wrap.
- Mid-stream clear with 2 bytes buffered and in_valid high -> next cycle out_valid=0, count=0, state ACTIVE, next accepted byte at addr 0.
